// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// Operand forwarding and load-use hazard detection for a five-stage MIPS
// pipeline. The unit keeps its own copy of the destination tags of the
// instructions in EX, MEM and WB. It compares those tags against the source
// registers of the instruction in ID (to stall) and of the instruction in EX
// (to pick a forwarded operand). It also keeps a saturating count of stall
// cycles. With FWD_EN=0 nothing is forwarded, and ID waits until every
// producer has left WB.
module fwd_hazard_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NPORTS = 2,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNTW   = 32
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     id_valid_i,
    input  logic [NPORTS*5-1:0]      id_rs_i,
    input  logic [NPORTS-1:0]        id_rs_used_i,
    input  logic [4:0]               id_rd_i,
    input  logic                     id_wr_i,
    input  logic                     id_is_load_i,
    input  logic [NPORTS*XLEN-1:0]   id_regval_i,
    input  logic                     flush_i,
    input  logic [XLEN-1:0]          exmem_value_i,
    input  logic [XLEN-1:0]          memwb_value_i,
    output logic                     stall_o,
    output logic [NPORTS*XLEN-1:0]   ex_opnd_o,
    output logic [NPORTS*2-1:0]      ex_fwd_sel_o,
    output logic [CNTW-1:0]          stall_count_o
);

    localparam logic            FWD      = (FWD_EN != 0);
    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
    localparam logic [1:0]      SEL_CAP  = 2'b00;
    localparam logic [1:0]      SEL_WB   = 2'b01;
    localparam logic [1:0]      SEL_MEM  = 2'b10;
    localparam logic [1:0]      SEL_ZERO = 2'b11;

    // A producer matches register r only if it is live, writes, and its
    // destination is not r0. This keeps r0 from forwarding or stalling.
    function automatic logic hits(input logic v, input logic w,
                                  input logic [4:0] rd, input logic [4:0] r);
        return v & w & (rd == r) & (rd != 5'd0);
    endfunction

    // EX-stage tags and operands captured at issue
    logic                   ex_valid_q, ex_valid_d;
    logic [4:0]             ex_rd_q, ex_rd_d;
    logic                   ex_wr_q, ex_wr_d;
    logic                   ex_load_q, ex_load_d;
    logic [NPORTS*5-1:0]    ex_rs_q, ex_rs_d;
    logic [NPORTS*XLEN-1:0] ex_val_q, ex_val_d;

    // MEM-stage tags
    logic                   mem_valid_q, mem_valid_d;
    logic [4:0]             mem_rd_q, mem_rd_d;
    logic                   mem_wr_q, mem_wr_d;
    logic                   mem_load_q, mem_load_d;

    // WB-stage tags
    logic                   wb_valid_q, wb_valid_d;
    logic [4:0]             wb_rd_q, wb_rd_d;
    logic                   wb_wr_q, wb_wr_d;

    logic [CNTW-1:0]        cnt_q, cnt_d;

    logic [NPORTS-1:0]      port_haz;
    logic [NPORTS*XLEN-1:0] cap_val;
    logic                   hazard;
    logic                   stall;
    logic                   load_ex;

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            logic [4:0]      id_r;
            logic [4:0]      ex_r;
            logic            id_hit_ex;
            logic            id_hit_mem;
            logic            id_hit_wb;
            logic            ex_hit_mem;
            logic            ex_hit_wb;
            logic [1:0]      sel;
            logic [XLEN-1:0] opnd;

            assign id_r = id_rs_i[5*gi +: 5];
            assign ex_r = ex_rs_q[5*gi +: 5];

            // Compare the ID source register with each producer still in flight
            assign id_hit_ex  = hits(ex_valid_q,  ex_wr_q,  ex_rd_q,  id_r);
            assign id_hit_mem = hits(mem_valid_q, mem_wr_q, mem_rd_q, id_r);
            assign id_hit_wb  = hits(wb_valid_q,  wb_wr_q,  wb_rd_q,  id_r);

            // With forwarding, only a load directly ahead has to stall. Without
            // forwarding, any producer that has not retired forces a stall.
            // Unused ports never stall.
            assign port_haz[gi] = id_rs_used_i[gi] &
                                  (FWD ? (id_hit_ex & ex_load_q)
                                       : (id_hit_ex | id_hit_mem | id_hit_wb));

            // The register file write in WB is not visible in the ID read
            // in the same cycle, so the WB value is taken directly at capture.
            assign cap_val[gi*XLEN +: XLEN] =
                id_hit_wb ? memwb_value_i : id_regval_i[gi*XLEN +: XLEN];

            // Compare the EX source register with the producers ahead of it
            assign ex_hit_mem = hits(mem_valid_q, mem_wr_q, mem_rd_q, ex_r);
            assign ex_hit_wb  = hits(wb_valid_q,  wb_wr_q,  wb_rd_q,  ex_r);

            // Operand mux: r0, then the youngest forwarding source, then the
            // captured value. A load in MEM has no data yet, so it is skipped.
            // The stall keeps a dependent instruction from reaching this point.
            always_comb begin
                sel  = SEL_CAP;
                opnd = ex_val_q[gi*XLEN +: XLEN];
                if (ex_r == 5'd0) begin
                    sel  = SEL_ZERO;
                    opnd = '0;
                end else if (FWD && ex_hit_mem && !mem_load_q) begin
                    sel  = SEL_MEM;
                    opnd = exmem_value_i;
                end else if (FWD && ex_hit_wb) begin
                    sel  = SEL_WB;
                    opnd = memwb_value_i;
                end
            end

            assign ex_opnd_o[gi*XLEN +: XLEN] = opnd;
            assign ex_fwd_sel_o[2*gi +: 2]    = sel;
        end
    endgenerate

    assign hazard  = |port_haz;
    // A flush kills the instruction in ID, so a hazard it carries is irrelevant
    assign stall   = id_valid_i & hazard & ~flush_i;
    assign load_ex = id_valid_i & ~stall & ~flush_i;

    // Next-state: EX takes the ID instruction or a bubble. MEM and WB always
    // shift. The counter saturates at all-ones.
    always_comb begin
        ex_valid_d = load_ex;
        ex_rd_d    = ex_rd_q;
        ex_wr_d    = ex_wr_q;
        ex_load_d  = ex_load_q;
        ex_rs_d    = ex_rs_q;
        ex_val_d   = ex_val_q;
        if (load_ex) begin
            ex_rd_d   = id_rd_i;
            ex_wr_d   = id_wr_i;
            ex_load_d = id_is_load_i;
            ex_rs_d   = id_rs_i;
            ex_val_d  = cap_val;
        end

        mem_valid_d = ex_valid_q;
        mem_rd_d    = ex_rd_q;
        mem_wr_d    = ex_wr_q;
        mem_load_d  = ex_load_q;

        wb_valid_d  = mem_valid_q;
        wb_rd_d     = mem_rd_q;
        wb_wr_d     = mem_wr_q;

        cnt_d = cnt_q;
        if (stall && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    // State registers. Reset empties the pipeline, so the outputs read as
    // r0 operands with no stall.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_wr_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_rs_q     <= '0;
            ex_val_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_wr_q    <= 1'b0;
            mem_load_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_wr_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_wr_q     <= ex_wr_d;
            ex_load_q   <= ex_load_d;
            ex_rs_q     <= ex_rs_d;
            ex_val_q    <= ex_val_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_load_q  <= mem_load_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_wr_q     <= wb_wr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign stall_o       = stall;
    assign stall_count_o = cnt_q;

endmodule
